// File: rtl/lcd_pkg.sv
// Shared definitions for the 8080-style LCD bus controllers.
// The state encoding is common to the read and write controllers.
package lcd_pkg;

  localparam int unsigned LcdDw = 16;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCmdWr   = 3'd1,
    StCmdHold = 3'd2,
    StTurn    = 3'd3,
    StRdLo    = 3'd4,
    StRdHi    = 3'd5,
    StFinish  = 3'd6
  } lcd_state_e;

endpackage

// File: rtl/lcd_phase_cnt.sv
// Loadable down-counter that times the RD low/high phases.
// The zero flag marks the last cycle of the current phase.
module lcd_phase_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lcd_read_ctrl.sv
// Read-side LCD bus controller: one command write, bus turnaround, then N data reads
// (optionally preceded by a discarded dummy read). All bus outputs decode the state register.
module lcd_read_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned DW      = LcdDw,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RD_LOW  = 3,
  parameter int unsigned RD_HIGH = 2,
  parameter int unsigned DUMMY   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [DW-1:0]    cmd,
  input  logic [CNT_W-1:0] rd_count,
  output logic [DW-1:0]    rdata,
  output logic             rdata_valid,
  output logic             busy,
  output logic             done,
  output logic             LCD_CS,
  output logic             LCD_RS,
  output logic             LCD_WR,
  output logic             LCD_RD,
  output logic [DW-1:0]    LCD_DB_OUT,
  output logic             LCD_DB_OE,
  input  logic [DW-1:0]    LCD_DB_IN
);

  localparam int unsigned PhMax = (RD_LOW > RD_HIGH) ? RD_LOW : RD_HIGH;
  localparam int unsigned PhW   = (PhMax > 1) ? $clog2(PhMax) : 1;
  localparam int unsigned RemW  = CNT_W + 1;
  localparam logic [PhW-1:0]  LoLoad   = PhW'(RD_LOW - 1);
  localparam logic [PhW-1:0]  HiLoad   = PhW'(RD_HIGH - 1);
  localparam logic [RemW-1:0] DummyRem = RemW'(DUMMY);

  lcd_state_e      r_state, w_next;
  logic [DW-1:0]   r_cmd;
  logic [DW-1:0]   r_rdata;
  logic [RemW-1:0] r_rem;
  logic            r_dummy;
  logic            r_rdata_valid;
  logic            w_ph_load;
  logic [PhW-1:0]  w_ph_val;
  logic            w_ph_zero;

  lcd_phase_cnt #(
    .W (PhW)
  ) u_phase_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_ph_load),
    .i_load_val (w_ph_val),
    .o_zero     (w_ph_zero)
  );

  always_comb begin
    w_next    = r_state;
    w_ph_load = 1'b0;
    w_ph_val  = LoLoad;
    case (r_state)
      StIdle:    if (start) w_next = StCmdWr;
      StCmdWr:   w_next = StCmdHold;
      StCmdHold: w_next = StTurn;
      StTurn: begin
        // rem still holds rd_count+DUMMY here, so this tests rd_count==0
        if (r_rem == DummyRem) begin
          w_next = StFinish;
        end else begin
          w_next    = StRdLo;
          w_ph_load = 1'b1;
        end
      end
      StRdLo: begin
        if (w_ph_zero) begin
          w_next    = StRdHi;
          w_ph_load = 1'b1;
          w_ph_val  = HiLoad;
        end
      end
      StRdHi: begin
        if (w_ph_zero) begin
          if (r_rem == '0) begin
            w_next = StFinish;
          end else begin
            w_next    = StRdLo;
            w_ph_load = 1'b1;
          end
        end
      end
      StFinish:  w_next = StIdle;
      default:   w_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= StIdle;
      r_cmd         <= '0;
      r_rdata       <= '0;
      r_rem         <= '0;
      r_dummy       <= 1'b0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_rdata_valid <= 1'b0;
      if (r_state == StIdle && start) begin
        r_cmd   <= cmd;
        r_rem   <= {1'b0, rd_count} + DummyRem;
        r_dummy <= (DUMMY != 0);
      end
      if (r_state == StRdLo && w_ph_zero) begin
        r_rdata       <= LCD_DB_IN;
        r_rem         <= r_rem - 1'b1;
        r_rdata_valid <= !r_dummy;
        r_dummy       <= 1'b0;
      end
    end
  end

  always_comb begin
    LCD_CS    = 1'b1;
    LCD_RS    = 1'b1;
    LCD_WR    = 1'b1;
    LCD_RD    = 1'b1;
    LCD_DB_OE = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      StCmdWr: begin
        LCD_CS = 1'b0; LCD_RS = 1'b0; LCD_WR = 1'b0; LCD_DB_OE = 1'b1; busy = 1'b1;
      end
      StCmdHold: begin
        LCD_CS = 1'b0; LCD_RS = 1'b0; LCD_DB_OE = 1'b1; busy = 1'b1;
      end
      StTurn, StRdHi: begin
        LCD_CS = 1'b0; busy = 1'b1;
      end
      StRdLo: begin
        LCD_CS = 1'b0; LCD_RD = 1'b0; busy = 1'b1;
      end
      StFinish: begin
        busy = 1'b1; done = 1'b1;
      end
      default: ;
    endcase
  end

  assign LCD_DB_OUT  = LCD_DB_OE ? r_cmd : '0;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Scoreboard bench for lcd_read_ctrl: default instance plus a DUMMY=0, 1/1-cycle RD instance.
module tb_lcd_read_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0, start6 = 1'b0;
  logic [15:0] cmd = '0, cmd6 = '0;
  logic [7:0]  rd_count = '0, rd_count6 = '0;
  logic [15:0] rdata, rdata6, db_out, db_out6;
  logic [15:0] db_in = '0, db_in6 = '0;
  logic rdata_valid, busy, done, cs, rs, wr, rd, oe;
  logic rdata_valid6, busy6, done6, cs6, rs6, wr6, rd6, oe6;

  lcd_read_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .cmd(cmd), .rd_count(rd_count),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done),
    .LCD_CS(cs), .LCD_RS(rs), .LCD_WR(wr), .LCD_RD(rd),
    .LCD_DB_OUT(db_out), .LCD_DB_OE(oe), .LCD_DB_IN(db_in)
  );

  lcd_read_ctrl #(.DUMMY(0), .RD_LOW(1), .RD_HIGH(1)) dut6 (
    .clk(clk), .rstn(rstn), .start(start6), .cmd(cmd6), .rd_count(rd_count6),
    .rdata(rdata6), .rdata_valid(rdata_valid6), .busy(busy6), .done(done6),
    .LCD_CS(cs6), .LCD_RS(rs6), .LCD_WR(wr6), .LCD_RD(rd6),
    .LCD_DB_OUT(db_out6), .LCD_DB_OE(oe6), .LCD_DB_IN(db_in6)
  );

  typedef struct {logic [15:0] data; int cyc;} exp_t;
  typedef struct {int cyc; int busy_len;} done_t;
  exp_t  exp_q[$], exp6_q[$];
  done_t done_q[$], done6_q[$];
  logic [15:0] bus_q[$], bus6_q[$];

  int cyc = 0;
  int n_checks = 0, n_errors = 0;
  int rd_falls = 0, rd6_falls = 0;
  int busy_run = 0, busy6_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, req, cyc);
    end
  endtask

  // Panel model: present the next queued word when RD falls
  always @(negedge rd) begin
    rd_falls++;
    if (bus_q.size() > 0) db_in = bus_q.pop_front();
  end
  always @(negedge rd6) begin
    rd6_falls++;
    if (bus6_q.size() > 0) db_in6 = bus6_q.pop_front();
  end

  always @(negedge clk) begin
    exp_t  e;
    done_t d;
    if (busy) busy_run++; else busy_run = 0;
    if (busy6) busy6_run++; else busy6_run = 0;
    if (rdata_valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", rdata_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("rdata", rdata, e.data);
        check("valid_cyc", cyc, e.cyc);
      end
    end
    if (done) begin
      if (done_q.size() == 0) check("unexpected_done", done, 0);
      else begin
        d = done_q.pop_front();
        check("done_cyc", cyc, d.cyc);
        check("busy_len", busy_run, d.busy_len);
      end
    end
    if (rdata_valid6) begin
      if (exp6_q.size() == 0) check("unexpected_valid6", rdata_valid6, 0);
      else begin
        e = exp6_q.pop_front();
        check("rdata6", rdata6, e.data);
        check("valid6_cyc", cyc, e.cyc);
      end
    end
    if (done6) begin
      if (done6_q.size() == 0) check("unexpected_done6", done6, 0);
      else begin
        d = done6_q.pop_front();
        check("done6_cyc", cyc, d.cyc);
        check("busy6_len", busy6_run, d.busy_len);
      end
    end
  end

  // Returns base such that cycle cN is observed with cyc == base + N
  task automatic issue(input logic [15:0] c, input logic [7:0] n, output int base);
    @(negedge clk);
    start = 1'b1; cmd = c; rd_count = n;
    @(negedge clk);
    start = 1'b0; cmd = 16'hDEAD; rd_count = 8'hFF;
    base = cyc - 1;
  endtask

  task automatic issue6(input logic [15:0] c, input logic [7:0] n, output int base);
    @(negedge clk);
    start6 = 1'b1; cmd6 = c; rd_count6 = n;
    @(negedge clk);
    start6 = 1'b0; cmd6 = 16'hDEAD; rd_count6 = 8'h00;
    base = cyc - 1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_cs"}, cs, 1);
    check({name, "_rs"}, rs, 1);
    check({name, "_wr"}, wr, 1);
    check({name, "_rd"}, rd, 1);
    check({name, "_oe"}, oe, 0);
    check({name, "_dbout"}, db_out, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_valid"}, rdata_valid, 0);
  endtask

  initial begin
    int base, r0;

    // T1: reset with start held
    #1 rstn = 1'b0;
    start = 1'b1; cmd = 16'h1234; rd_count = 8'd3;
    @(negedge clk);
    check_idle("t1_reset");
    check("t1_rdata", rdata, 0);
    repeat (3) begin
      @(negedge clk);
      check("t1_busy_held", busy, 0);
    end
    start = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_busy_after", busy, 0);

    // T2: dummy read then two real words
    bus_q = '{16'hAAAA, 16'h9341, 16'h0093};
    issue(16'h00D3, 8'd2, base);
    check("t2_wr_c1", wr, 0);
    check("t2_dbout_c1", db_out, 16'h00D3);
    check("t2_oe_c1", oe, 1);
    check("t2_rs_c1", rs, 0);
    check("t2_cs_c1", cs, 0);
    exp_q.push_back('{16'h9341, base + 12});
    exp_q.push_back('{16'h0093, base + 17});
    done_q.push_back('{base + 19, 19});
    repeat (21) @(negedge clk);
    check("t2_rdata_hold", rdata, 16'h0093);
    check_idle("t2_end");

    // T3: zero-length read
    r0 = rd_falls;
    issue(16'h0004, 8'd0, base);
    done_q.push_back('{base + 4, 4});
    repeat (6) @(negedge clk);
    check("t3_no_rd", rd_falls - r0, 0);

    // T4: start while busy and in FINISH is dropped; next cycle accepted
    bus_q = '{16'h1111, 16'h2222};
    issue(16'h002A, 8'd1, base);
    exp_q.push_back('{16'h2222, base + 12});
    done_q.push_back('{base + 14, 14});
    repeat (4) @(negedge clk);
    start = 1'b1; cmd = 16'h0055; rd_count = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("t4_done_c14", done, 1);
    start = 1'b1; cmd = 16'h0077; rd_count = 8'd0;
    done_q.push_back('{base + 19, 4});
    repeat (2) @(negedge clk);
    start = 1'b0; cmd = 16'h0000;
    check("t4_new_wr", wr, 0);
    check("t4_new_dbout", db_out, 16'h0077);
    repeat (6) @(negedge clk);

    // T5: reset during second RD low phase
    bus_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    issue(16'h000D, 8'd2, base);
    repeat (9) @(negedge clk);
    check("t5_rd_low", rd, 0);
    rstn = 1'b0;
    #1;
    check_idle("t5_async");
    @(negedge clk);
    rstn = 1'b1;
    bus_q.delete();
    repeat (2) @(negedge clk);
    bus_q = '{16'h5555, 16'h6666};
    issue(16'h000E, 8'd1, base);
    exp_q.push_back('{16'h6666, base + 12});
    done_q.push_back('{base + 14, 14});
    repeat (16) @(negedge clk);

    // T6: no dummy, single-cycle phases, 255 words
    for (int k = 0; k < 255; k++) bus6_q.push_back(16'h1000 + 16'(k));
    r0 = rd6_falls;
    issue6(16'h002E, 8'd255, base);
    for (int k = 0; k < 255; k++) exp6_q.push_back('{16'h1000 + 16'(k), base + 5 + 2 * k});
    done6_q.push_back('{base + 514, 514});
    repeat (520) @(negedge clk);
    check("t6_rd_falls", rd6_falls - r0, 255);

    check("exp_q_empty", exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    check("exp6_q_empty", exp6_q.size(), 0);
    check("done6_q_empty", done6_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
